sequential_multiplicator_arbiter: RTL and testbench
===================================================

// Module: sequential_multiplicator_arbiter
// PURPOSE
//   Shares one sequential_multiplicator between NUM_REQ requesters.
//   - Accepts operand pairs over per-requester valid/ready handshakes and picks one requester round-robin.
//   - Sequences the multiplier's start/done protocol.
//   - Returns product/overflow on a single response channel tagged with the requester id.
//   - Sits between client blocks and the shared multiplier instance.
// PARAMETERS
//   WIDTH          8   operand width; product is 2*WIDTH
//   NUM_REQ        4   number of requesters (>=2)
//   ID_W           2   response id width, $clog2(NUM_REQ)
//   TIMEOUT_CYCLES 64  WAIT-state watchdog limit (used only with SEQ_MUL_ARB_TIMEOUT_EN)
// PORTS
//   clock                 in   1              system clock, rising edge
//   reset_in              in   1              asynchronous, active-low reset
//   req_valid_in          in   NUM_REQ        per-requester operand valid
//   req_ready_out         out  NUM_REQ        per-requester accept; one-hot or zero
//   req_multiplicand_in   in   NUM_REQ*WIDTH  packed; requester i at [i*WIDTH +: WIDTH]
//   req_multiplier_in     in   NUM_REQ*WIDTH  packed, same layout
//   resp_valid_out        out  1              response valid
//   resp_ready_in         in   1              response consumer ready
//   resp_id_out           out  ID_W           index of the served requester
//   resp_product_out      out  2*WIDTH        latched product
//   resp_overflow_out     out  1              latched overflow
//   resp_error_out        out  1              watchdog abort flag; constant 0 when the feature is off
//   mul_multiplicand_out  out  WIDTH          to multiplier
//   mul_multiplier_out    out  WIDTH          to multiplier
//   mul_start_out         out  1              one-cycle start pulse
//   mul_reset_out         out  1              active-low reset to multiplier
//   mul_done_in           in   1              from multiplier
//   mul_product_in        in   2*WIDTH        from multiplier
//   mul_overflow_in       in   1              from multiplier
// BEHAVIOUR
//   Reset (reset_in=0, async):
//     - state=IDLE, rr pointer=0, all outputs 0.
//     - Exception: mul_reset_out mirrors reset_in (low).
//   FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
//   IDLE
//     - If any req_valid_in is high, grant g = first valid at or after rr pointer, cyclically.
//     - Same cycle: req_ready_out[g]=1 (combinational), so the transfer happens at that edge.
//     - At that edge: latch operands into mul_* outputs, rr <= g+1 mod NUM_REQ, id <= g, go START.
//     - If no valid: all req_ready_out = 0.
//   START
//     - mul_start_out=1 for exactly one cycle, then go WAIT.
//     - Operands stay stable on mul_* outputs from grant until RESP exits.
//   WAIT
//     - Done is edge-detected: done_prev is registered every cycle.
//     - Completion = mul_done_in & ~done_prev, sampled in WAIT only.
//     - On completion: latch product/overflow, go RESP.
//     - A done level held from a previous op is never taken as completion.
//   RESP
//     - resp_valid_out=1. Hold id, product, overflow and error stable until resp_valid_out & resp_ready_in, then IDLE.
//     - No new grant while in START, WAIT or RESP; req_ready_out all 0.
//   Latency
//     - Grant edge to start pulse: 1 cycle.
//     - Done edge to resp_valid_out: 1 cycle.
//     - Min turnaround to the next grant: 1 cycle after the response handshake.
//   Fairness
//     - A requester holding valid is served within NUM_REQ grants.
//     - req_valid_in dropping before grant is legal; no transfer occurs.
//   Reset mid-operation: aborts immediately; no response is emitted.
// CONFIGURATION
//   SEQ_MUL_ARB_TIMEOUT_EN defined:
//     - Cycle counter runs in WAIT.
//     - When it reaches TIMEOUT_CYCLES without completion: drive mul_reset_out=0 for one cycle.
//     - Then go RESP with product=0, overflow=0, resp_error_out=1.
//     - Counter clears on WAIT entry.
//   Undefined:
//     - No counter; WAIT lasts until completion.
//     - resp_error_out tied 0; mul_reset_out = reset_in.
// TESTING
//   1. Single req0: 5*7, WIDTH=8 -> one start pulse, resp id=0, product=35, overflow = model value, error=0.
//   2. req0..3 all valid continuously -> grant order 0,1,2,3,0; each id matches its operands.
//   3. resp_ready_in low 10 cycles during RESP -> resp fields stable; no req_ready_out asserted.
//   4. done held high between ops -> second op completes only on the new rising edge, not early.
//   5. reset_in low during WAIT -> all outputs 0 async; no response; rr pointer=0 after release.
//   6. TIMEOUT_EN, multiplier done tied 0 -> after 64 WAIT cycles: mul_reset_out low 1 cycle; resp error=1, product=0.

Source files
------------

// File: rtl/sequential_multiplicator_arbiter.sv
// Round-robin front end sharing one sequential multiplier among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SEQ_MUL_ARB_TIMEOUT_EN.
module sequential_multiplicator_arbiter #(
  parameter int WIDTH          = 8,
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_multiplier_in,
  output logic                     resp_valid_out,
  input  logic                     resp_ready_in,
  output logic [ID_W-1:0]          resp_id_out,
  output logic [2*WIDTH-1:0]       resp_product_out,
  output logic                     resp_overflow_out,
  output logic                     resp_error_out,
  output logic [WIDTH-1:0]         mul_multiplicand_out,
  output logic [WIDTH-1:0]         mul_multiplier_out,
  output logic                     mul_start_out,
  output logic                     mul_reset_out,
  input  logic                     mul_done_in,
  input  logic [2*WIDTH-1:0]       mul_product_in,
  input  logic                     mul_overflow_in
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 || (1 << ID_W) < NUM_REQ) begin : g_bad_params
    $error("sequential_multiplicator_arbiter: illegal parameter set");
  end

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               start_q, start_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               overflow_q, overflow_d;
  logic               resp_valid_q, resp_valid_d;
  logic               done_prev_q;

  logic               grant_found_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W-1:0]    cand_s;
  logic [WIDTH-1:0]   sel_mcand_s;
  logic [WIDTH-1:0]   sel_mplier_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic               done_rise_s;

  assign done_rise_s = mul_done_in & ~done_prev_q;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!grant_found_s && req_valid_in[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_mcand_s  = '0;
    sel_mplier_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx_s == ID_W'(k)) begin
        sel_mcand_s  = req_multiplicand_in[k*WIDTH +: WIDTH];
        sel_mplier_s = req_multiplier_in[k*WIDTH +: WIDTH];
      end else begin
        sel_mcand_s  = sel_mcand_s;
        sel_mplier_s = sel_mplier_s;
      end
    end
  end

  // Accept is combinational so the transfer completes on the grant edge.
  always_comb begin
    req_ready_s = '0;
    if (state_q == S_IDLE && grant_found_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

`ifdef SEQ_MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             error_q, error_d;

  // Next-state and datapath with the WAIT watchdog.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    start_d      = 1'b0;
    product_d    = product_q;
    overflow_d   = overflow_q;
    resp_valid_d = resp_valid_q;
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          mcand_d  = sel_mcand_s;
          mplier_d = sel_mplier_s;
          id_d     = grant_idx_s;
          rr_d     = ID_W'((int'(grant_idx_s) + 1) % NUM_REQ);
          start_d  = 1'b1;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise_s) begin
          product_d    = mul_product_in;
          overflow_d   = mul_overflow_in;
          error_d      = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expiry: pulse the multiplier reset and report an error response.
          product_d    = '0;
          overflow_d   = 1'b0;
          error_d      = 1'b1;
          abort_d      = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // Watchdog registers.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      error_q <= error_d;
    end
  end

  assign resp_error_out = error_q;
  assign mul_reset_out  = reset_in & ~abort_q;
`else
  // Next-state and datapath; WAIT lasts until the multiplier completes.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    start_d      = 1'b0;
    product_d    = product_q;
    overflow_d   = overflow_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_s) begin
          mcand_d  = sel_mcand_s;
          mplier_d = sel_mplier_s;
          id_d     = grant_idx_s;
          rr_d     = ID_W'((int'(grant_idx_s) + 1) % NUM_REQ);
          start_d  = 1'b1;
          state_d  = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise_s) begin
          product_d    = mul_product_in;
          overflow_d   = mul_overflow_in;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  assign resp_error_out = 1'b0;
  assign mul_reset_out  = reset_in;
`endif

  // Main state and datapath registers; done_prev samples every cycle for edge detection.
  always_ff @(posedge clock or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      start_q      <= 1'b0;
      product_q    <= '0;
      overflow_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      done_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      start_q      <= start_d;
      product_q    <= product_d;
      overflow_q   <= overflow_d;
      resp_valid_q <= resp_valid_d;
      done_prev_q  <= mul_done_in;
    end
  end

  assign req_ready_out        = req_ready_s;
  assign resp_valid_out       = resp_valid_q;
  assign resp_id_out          = id_q;
  assign resp_product_out     = product_q;
  assign resp_overflow_out    = overflow_q;
  assign mul_multiplicand_out = mcand_q;
  assign mul_multiplier_out   = mplier_q;
  assign mul_start_out        = start_q;

endmodule

// File: tb/tb_sequential_multiplicator_arbiter.sv
// Directed bench for sequential_multiplicator_arbiter with a transaction-level reference model.
module tb_sequential_multiplicator_arbiter;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 64;

  logic                     clock;
  logic                     reset_in;
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand_in;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier_in;
  logic                     resp_valid_out;
  logic                     resp_ready_in;
  logic [ID_W-1:0]          resp_id_out;
  logic [2*WIDTH-1:0]       resp_product_out;
  logic                     resp_overflow_out;
  logic                     resp_error_out;
  logic [WIDTH-1:0]         mul_multiplicand_out;
  logic [WIDTH-1:0]         mul_multiplier_out;
  logic                     mul_start_out;
  logic                     mul_reset_out;
  logic                     mul_done_in;
  logic [2*WIDTH-1:0]       mul_product_in;
  logic                     mul_overflow_in;

  sequential_multiplicator_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_in(reset_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_multiplicand_in(req_multiplicand_in), .req_multiplier_in(req_multiplier_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_id_out(resp_id_out), .resp_product_out(resp_product_out),
    .resp_overflow_out(resp_overflow_out), .resp_error_out(resp_error_out),
    .mul_multiplicand_out(mul_multiplicand_out), .mul_multiplier_out(mul_multiplier_out),
    .mul_start_out(mul_start_out), .mul_reset_out(mul_reset_out),
    .mul_done_in(mul_done_in), .mul_product_in(mul_product_in),
    .mul_overflow_in(mul_overflow_in)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus operands per requester
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_arr[i] = a;
    b_arr[i] = b;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_multiplicand_in[k*WIDTH +: WIDTH] = a_arr[k];
      req_multiplier_in[k*WIDTH +: WIDTH]   = b_arr[k];
    end
  endtask

  // Fake multiplier: mode 0 = done pulse, 1 = done held until m_drop cycles after next start, 2 = never done
  int m_mode = 0;
  int m_lat  = 4;
  int m_drop = 3;
  int m_cnt  = 0;
  bit m_busy = 1'b0;
  logic [2*WIDTH-1:0] m_a, m_b;

  initial begin
    mul_done_in     = 1'b0;
    mul_product_in  = '0;
    mul_overflow_in = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_in || !mul_reset_out) begin
        m_busy      = 1'b0;
        mul_done_in = 1'b0;
      end else begin
        if (mul_done_in && m_mode == 0) mul_done_in = 1'b0;
        if (mul_start_out) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_a    = {8'd0, mul_multiplicand_out};
          m_b    = {8'd0, mul_multiplier_out};
        end else if (m_busy) begin
          m_cnt++;
          if (m_cnt == m_drop) mul_done_in = 1'b0;
          if (m_cnt == m_lat && m_mode != 2) begin
            mul_done_in     = 1'b1;
            mul_product_in  = m_a * m_b;
            mul_overflow_in = (m_a * m_b) > 16'd255;
            m_busy          = 1'b0;
          end
        end
      end
    end
  end

  // Reference model state: ph 0 idle, 1 start pulse due, 2 waiting, 3 response
  int ph = 0;
  int rr_m = 0;
  int cur_id = 0;
  logic [WIDTH-1:0]   cur_a, cur_b;
  logic [2*WIDTH-1:0] exp_prod;
  logic               exp_ovf, exp_err;
  int wait_cnt = 0;
  bit prev_done = 1'b0;
  bit prev_rv = 1'b0;
  bit abort_first = 1'b0;
  int cyc = 0;
  int start_seen = 0;
  int resp_seen = 0;
  int start_cnt = 0;
  int mrst_low_cnt = 0;
  int grant_log[$];
  int rid_l[$];
  int rprod_l[$];
  int rovf_l[$];
  int rerr_l[$];
  int idx, exp_g;
  bit exp_found;
  logic [NUM_REQ-1:0] exp_ready;

  // Compare process: checks every cycle against the model
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_in) begin
        check("rst_req_ready", req_ready_out, 0);
        check("rst_resp_valid", resp_valid_out, 0);
        check("rst_start", mul_start_out, 0);
        check("rst_mul_reset", mul_reset_out, 0);
        check("rst_mcand", mul_multiplicand_out, 0);
        check("rst_mplier", mul_multiplier_out, 0);
        check("rst_product", resp_product_out, 0);
        check("rst_id", resp_id_out, 0);
        check("rst_error", resp_error_out, 0);
        ph = 0; rr_m = 0; prev_done = 1'b0; prev_rv = 1'b0; abort_first = 1'b0;
      end else begin
        exp_found = 1'b0; exp_g = 0; exp_ready = '0;
        if (ph == 0) begin
          for (int k = 0; k < NUM_REQ; k++) begin
            idx = (rr_m + k) % NUM_REQ;
            if (!exp_found && req_valid_in[idx]) begin
              exp_found = 1'b1;
              exp_g = idx;
            end
          end
        end
        if (exp_found) exp_ready[exp_g] = 1'b1;
        check("req_ready", req_ready_out, exp_ready);
        check("resp_valid", resp_valid_out, ph == 3);
        check("start_pulse", mul_start_out, ph == 1);
        check("mul_reset", mul_reset_out, !(ph == 3 && abort_first));
`ifndef SEQ_MUL_ARB_TIMEOUT_EN
        check("error_tied", resp_error_out, 0);
`endif
        if (ph != 0) begin
          check("mul_mcand", mul_multiplicand_out, cur_a);
          check("mul_mplier", mul_multiplier_out, cur_b);
        end
        if (ph == 3) begin
          check("resp_id", resp_id_out, cur_id);
          check("resp_product", resp_product_out, exp_prod);
          check("resp_overflow", resp_overflow_out, exp_ovf);
          check("resp_error", resp_error_out, exp_err);
        end
        if (mul_start_out) begin start_cnt++; start_seen = cyc; end
        if (resp_valid_out && !prev_rv) resp_seen = cyc;
        if (!mul_reset_out) mrst_low_cnt++;
        prev_rv = resp_valid_out;
        case (ph)
          0: if (exp_found) begin
            cur_id   = exp_g;
            cur_a    = a_arr[exp_g];
            cur_b    = b_arr[exp_g];
            exp_prod = cur_a * cur_b;
            exp_ovf  = exp_prod > 16'd255;
            exp_err  = 1'b0;
            rr_m     = (exp_g + 1) % NUM_REQ;
            grant_log.push_back(exp_g);
            ph = 1;
          end
          1: begin ph = 2; wait_cnt = 0; end
          2: begin
            wait_cnt++;
            if (mul_done_in && !prev_done) ph = 3;
`ifdef SEQ_MUL_ARB_TIMEOUT_EN
            else if (wait_cnt == TMO) begin
              ph = 3; exp_prod = '0; exp_ovf = 1'b0; exp_err = 1'b1; abort_first = 1'b1;
            end
`endif
          end
          3: begin
            abort_first = 1'b0;
            if (resp_ready_in) begin
              rid_l.push_back(int'(resp_id_out));
              rprod_l.push_back(int'(resp_product_out));
              rovf_l.push_back(int'(resp_overflow_out));
              rerr_l.push_back(int'(resp_error_out));
              ph = 0;
            end
          end
          default: ph = 0;
        endcase
        prev_done = mul_done_in;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); rid_l.delete(); rprod_l.delete(); rovf_l.delete(); rerr_l.delete();
    start_cnt = 0; mrst_low_cnt = 0;
  endtask

  task automatic wait_grants(input int n, input int bound);
    int c = 0;
    while (grant_log.size() < n && c < bound) begin tick(); c++; end
    check("grant_wait_bound", grant_log.size() >= n, 1);
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (ph != 0 && c < bound) begin tick(); c++; end
    check("idle_wait_bound", ph == 0, 1);
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    repeat (3) tick();
    reset_in = 1'b1;
  endtask

  initial begin
    reset_in = 1'b0;
    req_valid_in = '0;
    resp_ready_in = 1'b1;
    req_multiplicand_in = '0;
    req_multiplier_in = '0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'd0, 8'd0);
    repeat (3) tick();
    reset_in = 1'b1;

    // 1: single request, 5*7
    clear_logs();
    m_mode = 0; m_lat = 4;
    set_op(0, 8'd5, 8'd7);
    req_valid_in = 4'b0001;
    wait_grants(1, 20);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t1_resp_count", rid_l.size(), 1);
    check("t1_id", rid_l[0], 0);
    check("t1_product", rprod_l[0], 35);
    check("t1_overflow", rovf_l[0], 0);
    check("t1_error", rerr_l[0], 0);
    check("t1_start_pulses", start_cnt, 1);
    check("t1_latency", resp_seen - start_seen, 5);

    // 2: all requesters valid, round-robin order
    do_reset();
    clear_logs();
    m_lat = 2;
    set_op(0, 8'd3, 8'd4);
    set_op(1, 8'd10, 8'd20);
    set_op(2, 8'd100, 8'd3);
    set_op(3, 8'd255, 8'd255);
    req_valid_in = 4'b1111;
    wait_grants(5, 200);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t2_grant0", grant_log[0], 0);
    check("t2_grant1", grant_log[1], 1);
    check("t2_grant2", grant_log[2], 2);
    check("t2_grant3", grant_log[3], 3);
    check("t2_grant4", grant_log[4], 0);
    check("t2_prod1", rprod_l[1], 200);
    check("t2_prod2", rprod_l[2], 300);
    check("t2_ovf2", rovf_l[2], 1);
    check("t2_prod3", rprod_l[3], 65025);
    check("t2_id4", rid_l[4], 0);
    check("t2_prod4", rprod_l[4], 12);

    // 3: response back-pressure for 10 cycles with another requester waiting
    clear_logs();
    resp_ready_in = 1'b0;
    set_op(2, 8'd200, 8'd3);
    set_op(1, 8'd9, 8'd9);
    req_valid_in = 4'b0100;
    wait_grants(1, 20);
    req_valid_in = 4'b0010;
    begin
      int c = 0;
      while (!resp_valid_out && c < 50) begin tick(); c++; end
    end
    check("t3_resp_seen", resp_valid_out, 1);
    repeat (10) tick();
    check("t3_held_product", resp_product_out, 600);
    check("t3_held_id", resp_id_out, 2);
    check("t3_no_ready", req_ready_out, 0);
    resp_ready_in = 1'b1;
    wait_grants(2, 50);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t3_id0", rid_l[0], 2);
    check("t3_ovf0", rovf_l[0], 1);
    check("t3_id1", rid_l[1], 1);
    check("t3_prod1", rprod_l[1], 81);

    // 4: done level held across operations
    clear_logs();
    m_mode = 1; m_lat = 6; m_drop = 3;
    set_op(3, 8'd15, 8'd15);
    req_valid_in = 4'b1000;
    wait_grants(1, 20);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t4_done_still_high", mul_done_in, 1);
    set_op(0, 8'd16, 8'd16);
    req_valid_in = 4'b0001;
    wait_grants(2, 20);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t4_latency", resp_seen - start_seen, 7);
    check("t4_prod0", rprod_l[0], 225);
    check("t4_prod1", rprod_l[1], 256);
    check("t4_ovf1", rovf_l[1], 1);
    m_mode = 0;

    // 5: reset during WAIT
    clear_logs();
    m_lat = 30;
    set_op(1, 8'd6, 8'd6);
    req_valid_in = 4'b0010;
    wait_grants(1, 20);
    req_valid_in = 4'b0000;
    repeat (5) tick();
    #2;
    reset_in = 1'b0;
    #1;
    check("t5_async_resp_valid", resp_valid_out, 0);
    check("t5_async_start", mul_start_out, 0);
    check("t5_async_mul_reset", mul_reset_out, 0);
    check("t5_async_mcand", mul_multiplicand_out, 0);
    check("t5_async_mplier", mul_multiplier_out, 0);
    check("t5_async_id", resp_id_out, 0);
    @(posedge clock);
    #1;
    tick();
    reset_in = 1'b1;
    m_lat = 3;
    set_op(0, 8'd1, 8'd2);
    set_op(2, 8'd3, 8'd4);
    req_valid_in = 4'b0101;
    wait_grants(3, 50);
    req_valid_in = 4'b0000;
    wait_idle(100);
    check("t5_first_after_reset", grant_log[1], 0);
    check("t5_second_after_reset", grant_log[2], 2);
    check("t5_resp_count", rid_l.size(), 2);
    check("t5_prod_a", rprod_l[0], 2);
    check("t5_prod_b", rprod_l[1], 12);

`ifdef SEQ_MUL_ARB_TIMEOUT_EN
    // 6: watchdog with done never asserted
    clear_logs();
    m_mode = 2;
    set_op(3, 8'd7, 8'd9);
    req_valid_in = 4'b1000;
    wait_grants(1, 20);
    req_valid_in = 4'b0000;
    wait_idle(200);
    check("t6_error", rerr_l[0], 1);
    check("t6_product", rprod_l[0], 0);
    check("t6_latency", resp_seen - start_seen, 65);
    check("t6_mul_reset_cycles", mrst_low_cnt, 1);
    m_mode = 0;
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
